// File: rtl/line_packer.sv
// Packs a stream of DATA_WIDTH elements into WAYS-wide lines and writes each
// completed line to a BRAM slice, tracking how many lines the reader still owes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | no lane held in assembly and no committed, unfreed lines
// S_FILL  | lanes held in assembly or 0 < used < RAM_DEPTH
// S_FULL  | used == RAM_DEPTH; input stalled until the reader frees a line
module line_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int WAYS       = 8,
  parameter int RAM_DEPTH  = 512,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int WAYS_WIDTH = $clog2(WAYS)
) (
  input  logic                       clk1x,
  input  logic                       reset,
  input  logic                       i_v,
  input  logic [DATA_WIDTH-1:0]      i_d,
  input  logic                       i_last,
  output logic                       o_r,
  output logic                       o_we,
  output logic [ADDR_WIDTH-1:0]      o_wa,
  output logic [WAYS*DATA_WIDTH-1:0] o_wd,
  input  logic                       i_free,
  output logic [ADDR_WIDTH:0]        o_used,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int                    LINE_W    = WAYS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0]   USED_MAX  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WP_LAST   = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [WAYS_WIDTH-1:0] LANE_LAST = WAYS_WIDTH'(WAYS - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [WAYS_WIDTH-1:0]   lane, lane_nxt;
  logic [ADDR_WIDTH-1:0]   wp, wp_nxt;
  logic [LINE_W-1:0]       asm_reg, asm_nxt, line_merged;
  logic [ADDR_WIDTH:0]     used, used_nxt;
  logic                    accept, complete, free_ok;

  // Ready comes straight from the state register so it never combinationally
  // depends on i_v or i_free.
  assign o_r     = (state != S_FULL);
  assign o_full  = (state == S_FULL);
  assign o_empty = (state == S_EMPTY);
  assign o_used  = used;

  always_ff @(posedge clk1x) begin
    if (!reset) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    accept      = i_v && o_r;
    line_merged = asm_reg;
    for (int k = 0; k < WAYS; k++) begin
      if (WAYS_WIDTH'(k) == lane) begin
        line_merged[k*DATA_WIDTH +: DATA_WIDTH] = i_d;
      end
    end
    complete = accept && ((lane == LANE_LAST) || i_last);

    lane_nxt = lane;
    asm_nxt  = asm_reg;
    wp_nxt   = wp;
    if (complete) begin
      lane_nxt = '0;
      asm_nxt  = '0;
      wp_nxt   = (wp == WP_LAST) ? '0 : wp + 1'b1;
    end else if (accept) begin
      lane_nxt = lane + 1'b1;
      asm_nxt  = line_merged;
    end

    // A free arriving with nothing committed only counts if a line lands now.
    free_ok  = i_free && ((used != '0) || complete);
    used_nxt = used;
    if (complete && !free_ok) begin
      used_nxt = used + 1'b1;
    end else if (!complete && free_ok) begin
      used_nxt = used - 1'b1;
    end

    state_nxt = state;
    case (state)
      S_FULL: begin
        if (i_free) begin
          state_nxt = S_FILL;
        end
      end
      default: begin
        if (used_nxt == USED_MAX) begin
          state_nxt = S_FULL;
        end else if ((used_nxt == '0) && (lane_nxt == '0)) begin
          state_nxt = S_EMPTY;
        end else begin
          state_nxt = S_FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk1x) begin
    if (!reset) begin
      lane    <= '0;
      wp      <= '0;
      asm_reg <= '0;
      used    <= '0;
      o_we    <= 1'b0;
      o_wa    <= '0;
      o_wd    <= '0;
    end else begin
      lane    <= lane_nxt;
      wp      <= wp_nxt;
      asm_reg <= asm_nxt;
      used    <= used_nxt;
      o_we    <= complete;
      if (complete) begin
        o_wa <= wp;
        o_wd <= line_merged;
      end
    end
  end

endmodule

// File: tb/tb_line_packer.sv
// Directed scenarios plus a random phase for line_packer, each cycle compared
// against a lane-array/counter reference model of the packing rules.
module tb_line_packer;

  localparam int DW    = 16;
  localparam int WAYS  = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int LW    = WAYS * DW;

  logic          clk1x = 1'b0;
  logic          reset, i_v, i_last, i_free;
  logic [DW-1:0] i_d;
  logic          o_r, o_we, o_full, o_empty;
  logic [AW-1:0] o_wa;
  logic [LW-1:0] o_wd;
  logic [AW:0]   o_used;

  always #5 clk1x = ~clk1x;

  line_packer #(
    .DATA_WIDTH(DW),
    .WAYS      (WAYS),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .clk1x  (clk1x),
    .reset  (reset),
    .i_v    (i_v),
    .i_d    (i_d),
    .i_last (i_last),
    .o_r    (o_r),
    .o_we   (o_we),
    .o_wa   (o_wa),
    .o_wd   (o_wd),
    .i_free (i_free),
    .o_used (o_used),
    .o_full (o_full),
    .o_empty(o_empty)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model: elements of the current line, line counters, last write
  logic [DW-1:0] m_lane [WAYS];
  int            m_n    = 0;
  int            m_wp   = 0;
  int            m_used = 0;
  bit            e_we   = 0;
  bit            e_rst  = 0;
  int            e_wa   = 0;
  logic [LW-1:0] e_wd   = '0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack_line();
    logic [LW-1:0] v = '0;
    for (int k = 0; k < WAYS; k++) v[k*DW +: DW] = m_lane[k];
    return v;
  endfunction

  task automatic clear_lanes();
    for (int k = 0; k < WAYS; k++) m_lane[k] = '0;
    m_n = 0;
  endtask

  task automatic step(input bit rst_n, input bit v, input logic [DW-1:0] d,
                      input bit last, input bit free);
    bit acc, comp;
    reset = rst_n; i_v = v; i_d = d; i_last = last; i_free = free;
    e_rst = !rst_n;
    comp  = 0;
    if (!rst_n) begin
      clear_lanes();
      m_wp = 0; m_used = 0; e_wa = 0; e_wd = '0;
    end else begin
      acc = v && (m_used != DEPTH);
      if (acc) begin
        m_lane[m_n] = d;
        m_n++;
        if (m_n == WAYS || last) comp = 1;
      end
      if (comp) begin
        e_wa = m_wp;
        e_wd = pack_line();
        clear_lanes();
        m_wp = (m_wp + 1) % DEPTH;
      end
      if (comp && free) begin
      end else if (comp) begin
        m_used++;
      end else if (free && m_used > 0) begin
        m_used--;
      end
    end
    e_we = comp;
    @(posedge clk1x);
    #1;
    cyc++;
    chk("o_we", LW'(o_we), LW'(e_we));
    if (e_we || e_rst) begin
      chk("o_wa", LW'(o_wa), LW'(e_wa));
      chk("o_wd", o_wd, e_wd);
    end
    chk("o_used", LW'(o_used), LW'(m_used));
    chk("o_full", LW'(o_full), LW'(m_used == DEPTH));
    chk("o_empty", LW'(o_empty), LW'(m_used == 0 && m_n == 0));
    chk("o_r", LW'(o_r), LW'(m_used != DEPTH));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 1, 16'h1234, 0, 1);
    step(0, 1, 16'h5678, 1, 1);
  endtask

  logic [LW-1:0] exp_line;
  int            last_we, npulses;

  initial begin
    reset = 1'b0; i_v = 1'b0; i_d = '0; i_last = 1'b0; i_free = 1'b0;
    clear_lanes();

    // reset values
    do_reset();
    chk("rst_r", LW'(o_r), LW'(1));
    chk("rst_empty", LW'(o_empty), LW'(1));

    // elements 1..8 back to back
    for (int i = 1; i <= 8; i++) step(1, 1, DW'(i), 0, 0);
    exp_line = '0;
    for (int k = 0; k < WAYS; k++) exp_line[k*DW +: DW] = DW'(k + 1);
    chk("full_line_we", LW'(o_we), LW'(1));
    chk("full_line_wa", LW'(o_wa), LW'(0));
    chk("full_line_wd", o_wd, exp_line);
    chk("full_line_used", LW'(o_used), LW'(1));
    idle(2);

    // short line closed by i_last
    do_reset();
    step(1, 1, 16'h000A, 0, 0);
    step(1, 1, 16'h000B, 1, 0);
    exp_line = '0;
    exp_line[DW-1:0]    = 16'h000A;
    exp_line[2*DW-1:DW] = 16'h000B;
    chk("partial_wd", o_wd, exp_line);
    step(1, 1, 16'h000C, 1, 0);
    chk("partial_next_wa", LW'(o_wa), LW'(1));

    // i_last on the final lane is a single write
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 1, DW'($urandom), 0, 0);
    step(1, 1, 16'h00EE, 1, 0);
    step(1, 0, '0, 0, 0);
    chk("last_on_lane7_single", LW'(o_we), LW'(0));
    chk("last_on_lane7_used", LW'(o_used), LW'(1));

    // fill to capacity, stall, free, wrap
    do_reset();
    for (int i = 0; i < 4 * WAYS; i++) step(1, 1, DW'($urandom), 0, 0);
    chk("cap_full", LW'(o_full), LW'(1));
    chk("cap_r", LW'(o_r), LW'(0));
    step(1, 1, 16'h0099, 1, 0);
    chk("cap_refused", LW'(o_we), LW'(0));
    step(1, 0, '0, 0, 1);
    chk("cap_r_after_free", LW'(o_r), LW'(1));
    for (int i = 0; i < WAYS; i++) step(1, 1, DW'($urandom), 0, 0);
    chk("wrap_we", LW'(o_we), LW'(1));
    chk("wrap_wa", LW'(o_wa), LW'(0));

    // completion and free in the same cycle
    do_reset();
    step(1, 1, 16'h0001, 1, 0);
    step(1, 1, 16'h0002, 1, 0);
    step(1, 1, 16'h0003, 1, 1);
    chk("same_cycle_used", LW'(o_used), LW'(2));

    // free with nothing committed is ignored
    do_reset();
    step(1, 0, '0, 0, 1);
    chk("idle_free_used", LW'(o_used), LW'(0));

    // reset mid-assembly discards the partial line
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, DW'(16'h0100 + i), 0, 0);
    step(0, 1, 16'h0200, 1, 1);
    chk("mid_rst_no_we", LW'(o_we), LW'(0));
    step(0, 1, 16'h0201, 1, 1);
    step(1, 1, 16'h0055, 0, 0);
    step(1, 1, 16'h0066, 1, 0);
    exp_line = '0;
    exp_line[DW-1:0]    = 16'h0055;
    exp_line[2*DW-1:DW] = 16'h0066;
    chk("post_rst_wa", LW'(o_wa), LW'(0));
    chk("post_rst_wd", o_wd, exp_line);

    // 16 lines streamed with the reader freeing after every write
    do_reset();
    last_we = -1;
    npulses = 0;
    for (int i = 0; i < 16 * WAYS + 3; i++) begin
      step(1, i < 16 * WAYS, DW'($urandom), 0, e_we);
      chk("stream_r", LW'(o_r), LW'(1));
      if (o_we === 1'b1) begin
        if (last_we >= 0) chk("stream_gap", LW'(cyc - last_we), LW'(8));
        last_we = cyc;
        npulses++;
      end
    end
    chk("stream_count", LW'(npulses), LW'(16));

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 149) != 0, $urandom_range(0, 3) != 0, DW'($urandom),
           $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
